// File: rtl/i2c_pkg.sv
// Shared constants for the single-byte I2C master: bus widths, FSM state codes
// and the quarter-phase encoding of one SCL bit period.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StStart = 4'd1;
    localparam logic [3:0] StAddr  = 4'd2;
    localparam logic [3:0] StAckA  = 4'd3;
    localparam logic [3:0] StWdata = 4'd4;
    localparam logic [3:0] StAckW  = 4'd5;
    localparam logic [3:0] StRdata = 4'd6;
    localparam logic [3:0] StMnack = 4'd7;
    localparam logic [3:0] StStop  = 4'd8;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_scl_gen.sv
// Quarter-period timebase: divides the system clock by ClkDiv and steps a
// 2-bit phase Q0..Q3 on every tick.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int unsigned ClkDiv = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    output logic       tick_o,
    output logic [1:0] phase_o
);

    localparam int unsigned CntW = $clog2(ClkDiv);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;

    assign tick_o  = en_i && !clr_i && (cnt_q == CntW'(ClkDiv - 1));
    assign phase_o = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr_i) begin
            cnt_d   = '0;
            phase_d = Q0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            phase_q <= Q0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, one data byte with ACK/NACK, STOP.
// SDA is open-drain (drive 0 or release); SCL is push-pull.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = I2C_ADDR_W,
    parameter int unsigned DATA_W  = I2C_DATA_W
) (
    input  logic              i2c_clk,
    input  logic              i2c_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              ack_err,
    output logic              i2c_scl,
    inout  wire               i2c_sda
);

    logic [3:0]        state_q, state_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d, wdata_q, wdata_d, rx_q, rx_d, rdata_q, rdata_d;
    logic              rw_q, rw_d, samp_q, samp_d, ack_err_q, ack_err_d, done_q, done_d;
    logic              tick, bit_end, samp_tick, sda_oe;
    logic [1:0]        phase;

    i2c_scl_gen #(
        .ClkDiv (CLK_DIV)
    ) u_scl_gen (
        .clk_i   (i2c_clk),
        .rst_i   (i2c_rst),
        .en_i    (busy),
        .clr_i   (!busy),
        .tick_o  (tick),
        .phase_o (phase)
    );

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign ack_err   = ack_err_q;
    assign rdata     = rdata_q;
    assign bit_end   = tick && (phase == Q3);
    assign samp_tick = tick && (phase == Q2);
    assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;

    always_comb begin
        i2c_scl = 1'b1;
        sda_oe  = 1'b0;
        case (state_q)
            StIdle:  ;
            StStart: sda_oe = phase[1];
            StAddr, StWdata: begin
                i2c_scl = phase[1];
                sda_oe  = ~sh_q[DATA_W-1];
            end
            StStop: begin
                i2c_scl = phase[1];
                sda_oe  = (phase != Q3);
            end
            default: i2c_scl = phase[1];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        samp_d    = samp_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (samp_tick) begin
            samp_d = i2c_sda;
            if (state_q == StRdata) rx_d = {rx_q[DATA_W-2:0], i2c_sda};
            if ((state_q == StAckA || state_q == StAckW) && i2c_sda) ack_err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StStart;
                    sh_d      = {addr, rw};
                    wdata_d   = wdata;
                    rw_d      = rw;
                    bit_d     = 3'd0;
                    ack_err_d = 1'b0;
                end
            end
            StStart: if (bit_end) state_d = StAddr;
            StAddr, StWdata: begin
                if (bit_end) begin
                    sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == StAddr) ? StAckA : StAckW;
                end
            end
            StAckA: begin
                if (bit_end) begin
                    if (samp_q) begin
                        state_d = StStop;
                    end else if (rw_q) begin
                        state_d = StRdata;
                    end else begin
                        state_d = StWdata;
                        sh_d    = wdata_q;
                    end
                end
            end
            StRdata: begin
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StMnack;
                        rdata_d = rx_q;
                    end
                end
            end
            StAckW, StMnack: if (bit_end) state_d = StStop;
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i2c_clk) begin
        if (i2c_rst) begin
            state_q   <= StIdle;
            bit_q     <= 3'd0;
            sh_q      <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rx_q      <= '0;
            rdata_q   <= '0;
            samp_q    <= 1'b1;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            samp_q    <= samp_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

endmodule
